// File: rtl/mem_bist_pkg.sv
// Shared state/phase encodings and the march data pattern for the memory self-test engine.
package mem_bist_pkg;

   localparam int unsigned STATE_W = 3;
   localparam int unsigned PHASE_W = 2;
   localparam int unsigned PAT_W   = 32;

   typedef logic [STATE_W-1:0] state_e;
   localparam state_e IDLE   = 3'd0;
   localparam state_e WR_ACC = 3'd1;
   localparam state_e WR_GAP = 3'd2;
   localparam state_e RD_ACC = 3'd3;
   localparam state_e RD_CMP = 3'd4;
   localparam state_e DONE   = 3'd5;

   typedef logic [PHASE_W-1:0] phase_e;
   localparam phase_e CLR_W = 2'd0;
   localparam phase_e CLR_R = 2'd1;
   localparam phase_e ADR_W = 2'd2;
   localparam phase_e ADR_R = 2'd3;

   // Clear phases use all-zero data, address phases use the zero-extended index.
   function automatic logic [PAT_W-1:0] pat(input phase_e ph, input logic [PAT_W-1:0] idx);
      return (ph == ADR_W || ph == ADR_R) ? idx : '0;
   endfunction

endpackage

// File: rtl/mem_bist_chk.sv
// Read-data compare with saturating error counter and first-failing-address capture.
module mem_bist_chk #(
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_,
   input  logic                  clear,
   input  logic                  en,
   input  logic [DATA_WIDTH-1:0] expected,
   input  logic [DATA_WIDTH-1:0] actual,
   input  logic [ADDR_WIDTH-1:0] idx,
   output logic [ADDR_WIDTH+1:0] err_count,
   output logic [ADDR_WIDTH-1:0] fail_addr,
   output logic                  err_zero_c
);

   localparam int unsigned CNT_W = ADDR_WIDTH + 2;

   logic [CNT_W-1:0]      err_count_q, err_count_d;
   logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
   logic                  miss_c;

   // Undriven or unknown read data must register as a miss, hence the case inequality.
   always_comb begin
      miss_c      = en && (actual !== expected);
      err_count_d = err_count_q;
      fail_addr_d = fail_addr_q;
      if (clear) begin
         err_count_d = '0;
         fail_addr_d = '0;
      end else if (miss_c) begin
         if (err_count_q != '1) err_count_d = err_count_q + CNT_W'(1);
         if (err_count_q == '0) fail_addr_d = idx;
      end
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         err_count_q <= '0;
         fail_addr_q <= '0;
      end else begin
         err_count_q <= err_count_d;
         fail_addr_q <= fail_addr_d;
      end
   end

   assign err_zero_c = (err_count_d == '0);
   assign err_count  = err_count_q;
   assign fail_addr  = fail_addr_q;

endmodule

// File: rtl/mem_bist.sv
// Two-phase march BIST (clear, then data=address) driving a single-port synchronous memory.
module mem_bist
   import mem_bist_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [ADDR_WIDTH+1:0] err_count,
   output logic [ADDR_WIDTH-1:0] fail_addr,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic [DATA_WIDTH-1:0] data_in,
   output logic                  write,
   output logic                  read,
   input  logic [DATA_WIDTH-1:0] data_out
);

   state_e                state_q, state_d;
   phase_e                phase_q, phase_d;
   logic [ADDR_WIDTH-1:0] idx_q, idx_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  pass_q, pass_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] data_in_q, data_in_d;
   logic                  write_q, write_d;
   logic                  read_q, read_d;
   logic                  accept_c, last_c, cmp_en_c, err_zero_c;
   logic [DATA_WIDTH-1:0] expected_c;

   assign last_c     = (idx_q == '1);
   assign cmp_en_c   = (state_q == RD_CMP);
   assign expected_c = DATA_WIDTH'(pat(phase_q, PAT_W'(idx_q)));

   // Next state; strobes and address/data are derived from the next state so they register alongside it.
   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      idx_d     = idx_q;
      busy_d    = busy_q;
      done_d    = done_q;
      pass_d    = pass_q;
      accept_c  = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               accept_c = 1'b1;
               state_d  = WR_ACC;
               phase_d  = CLR_W;
               idx_d    = '0;
               busy_d   = 1'b1;
               done_d   = 1'b0;
               pass_d   = 1'b0;
            end
         end
         WR_ACC: state_d = WR_GAP;
         WR_GAP: begin
            if (last_c) begin
               idx_d   = '0;
               phase_d = (phase_q == CLR_W) ? CLR_R : ADR_R;
               state_d = RD_ACC;
            end else begin
               idx_d   = idx_q + ADDR_WIDTH'(1);
               state_d = WR_ACC;
            end
         end
         RD_ACC: state_d = RD_CMP;
         RD_CMP: begin
            if (last_c) begin
               idx_d = '0;
               if (phase_q == CLR_R) begin
                  phase_d = ADR_W;
                  state_d = WR_ACC;
               end else begin
                  state_d = DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  pass_d  = err_zero_c;
               end
            end else begin
               idx_d   = idx_q + ADDR_WIDTH'(1);
               state_d = RD_ACC;
            end
         end
         default: state_d = IDLE;
      endcase

      write_d   = (state_d == WR_ACC);
      read_d    = (state_d == RD_ACC);
      addr_d    = addr_q;
      data_in_d = data_in_q;
      if (write_d || read_d) addr_d = idx_d;
      if (write_d) data_in_d = DATA_WIDTH'(pat(phase_d, PAT_W'(idx_d)));
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state_q   <= IDLE;
         phase_q   <= CLR_W;
         idx_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         addr_q    <= '0;
         data_in_q <= '0;
         write_q   <= 1'b0;
         read_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         idx_q     <= idx_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         pass_q    <= pass_d;
         addr_q    <= addr_d;
         data_in_q <= data_in_d;
         write_q   <= write_d;
         read_q    <= read_d;
      end
   end

   mem_bist_chk #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_chk (
      .clk        (clk),
      .rst_       (rst_),
      .clear      (accept_c),
      .en         (cmp_en_c),
      .expected   (expected_c),
      .actual     (data_out),
      .idx        (idx_q),
      .err_count  (err_count),
      .fail_addr  (fail_addr),
      .err_zero_c (err_zero_c)
   );

   assign busy    = busy_q;
   assign done    = done_q;
   assign pass    = pass_q;
   assign addr    = addr_q;
   assign data_in = data_in_q;
   assign write   = write_q;
   assign read    = read_q;

endmodule

// File: tb/tb_mem_bist.sv
// Bench for mem_bist: faulty-memory model, table of known faults, random faults vs an address-sweep model.
module tb_mem_bist;

   logic       clk;
   logic       rst_;
   logic       start;
   logic       busy, done, pass, write, read;
   logic [6:0] err_count;
   logic [4:0] fail_addr, addr;
   logic [7:0] data_in, data_out;

   logic [7:0] mem [32];
   logic [7:0] or_m, and_m, bad_v;
   logic       bad_en;
   logic [4:0] bad_a;

   int n_cmp, n_bad, n_wr, n_rd, proto_err;

   mem_bist #(.ADDR_WIDTH(5), .DATA_WIDTH(8)) dut (
      .clk       (clk),
      .rst_      (rst_),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .err_count (err_count),
      .fail_addr (fail_addr),
      .addr      (addr),
      .data_in   (data_in),
      .write     (write),
      .read      (read),
      .data_out  (data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] fread(input logic [4:0] a, input logic [7:0] v);
      logic [7:0] r;
      r = (v & and_m) | or_m;
      if (bad_en && a == bad_a) r = bad_v;
      return r;
   endfunction

   // Synchronous memory: read data appears the cycle after the read strobe.
   initial data_out = 8'h00;
   always @(posedge clk) begin
      if (write) mem[addr] <= data_in;
      if (read)  data_out  <= fread(addr, mem[addr]);
   end

   // Protocol monitor.
   logic       p_read, p_done, p_start;
   logic [4:0] p_addr;
   always @(negedge clk) begin
      if (!rst_) begin
         p_read = 1'b0; p_done = 1'b0; p_start = 1'b0; p_addr = 5'd0;
      end else begin
         if (write && read) begin
            proto_err++;
            $display("FAIL proto_wr_rd: write=%0b read=%0b, required not both high", write, read);
         end
         if (p_read && (read || addr != p_addr)) begin
            proto_err++;
            $display("FAIL proto_cmp: read=%0b addr=%0d after read of addr %0d, required read=0 same addr", read, addr, p_addr);
         end
         if (p_done && !done && !p_start) begin
            proto_err++;
            $display("FAIL proto_done: done=0 without accepted start, required 1");
         end
         if (write) n_wr++;
         if (read)  n_rd++;
         p_read = read; p_addr = addr; p_done = done; p_start = start;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic set_fault(input logic [7:0] om, input logic [7:0] am, input logic be,
                            input logic [4:0] ba, input logic [7:0] bv);
      or_m = om; and_m = am; bad_en = be; bad_a = ba; bad_v = bv;
   endtask

   // Reference: sweep both march phases over every address using the fault model directly.
   task automatic model(output int e, output int f);
      e = 0; f = 0;
      for (int ph = 0; ph < 2; ph++) begin
         for (int a = 0; a < 32; a++) begin
            logic [7:0] p;
            p = (ph == 0) ? 8'h00 : 8'(a);
            if (fread(5'(a), p) !== p) begin
               if (e == 0) f = a;
               if (e < 127) e++;
            end
         end
      end
   endtask

   // Returns cycles from acceptance to done, or -1 if a mid-run reset was applied.
   task automatic run_bist(input int extra_at, input int rst_at, output int cyc);
      n_wr = 0; n_rd = 0; proto_err = 0;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      chk("busy_rise", 32'(busy), 32'd1);
      chk("done_clear", 32'(done), 32'd0);
      cyc = 0;
      while (!done && cyc < 400) begin
         @(posedge clk);
         if (cyc == rst_at) begin
            #3 rst_ = 1'b0;
            #1 chk("rst_outputs_zero",
                   32'({busy, done, pass, err_count, fail_addr, addr, data_in, write, read}), 32'd0);
            @(posedge clk);
            #3 rst_ = 1'b1;
            cyc = -1;
            return;
         end
         #1;
         cyc++;
         start = (cyc == extra_at);
      end
      start = 1'b0;
   endtask

   task automatic check_run(input string tag, input int cyc, input int e, input int f, input logic p);
      chk({tag, "_cycles"}, 32'(cyc), 32'd256);
      chk({tag, "_err_count"}, 32'(err_count), 32'(e));
      chk({tag, "_fail_addr"}, 32'(fail_addr), 32'(f));
      chk({tag, "_pass"}, 32'(pass), 32'(p));
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_writes"}, 32'(n_wr), 32'd64);
      chk({tag, "_reads"}, 32'(n_rd), 32'd64);
      chk({tag, "_protocol"}, 32'(proto_err), 32'd0);
   endtask

   typedef struct {
      logic [7:0] om;
      logic [7:0] am;
      logic       be;
      logic [4:0] ba;
      logic [7:0] bv;
      int         e_err;
      int         e_fail;
      logic       e_pass;
   } vec_t;

   vec_t tbl [5];

   initial begin
      int cyc, e, f, kind;
      n_cmp = 0; n_bad = 0; n_wr = 0; n_rd = 0; proto_err = 0;
      tbl[0] = '{om:8'h00, am:8'hFF, be:1'b0, ba:5'd0,  bv:8'h00, e_err:0,  e_fail:0,  e_pass:1'b1};
      tbl[1] = '{om:8'h08, am:8'hFF, be:1'b0, ba:5'd0,  bv:8'h00, e_err:48, e_fail:0,  e_pass:1'b0};
      tbl[2] = '{om:8'h00, am:8'hFF, be:1'b1, ba:5'd17, bv:8'h5A, e_err:2,  e_fail:17, e_pass:1'b0};
      tbl[3] = '{om:8'h00, am:8'hFE, be:1'b0, ba:5'd0,  bv:8'h00, e_err:16, e_fail:1,  e_pass:1'b0};
      tbl[4] = '{om:8'h00, am:8'hEF, be:1'b0, ba:5'd0,  bv:8'h00, e_err:16, e_fail:16, e_pass:1'b0};

      set_fault(8'h00, 8'hFF, 1'b0, 5'd0, 8'h00);
      start = 1'b0;
      rst_  = 1'b0;
      repeat (2) @(posedge clk);
      #1 chk("reset_outputs_zero",
             32'({busy, done, pass, err_count, fail_addr, addr, data_in, write, read}), 32'd0);
      #2 rst_ = 1'b1;
      repeat (2) @(posedge clk);

      for (int i = 0; i < 5; i++) begin
         set_fault(tbl[i].om, tbl[i].am, tbl[i].be, tbl[i].ba, tbl[i].bv);
         run_bist(-1, -1, cyc);
         check_run($sformatf("tbl%0d", i), cyc, tbl[i].e_err, tbl[i].e_fail, tbl[i].e_pass);
         repeat (3) @(posedge clk);
      end

      // Second start while busy must be ignored.
      set_fault(8'h00, 8'hFF, 1'b0, 5'd0, 8'h00);
      run_bist(100, -1, cyc);
      check_run("restart_ignored", cyc, 0, 0, 1'b1);

      // Mid-run asynchronous reset, then a clean run.
      set_fault(8'h08, 8'hFF, 1'b0, 5'd0, 8'h00);
      run_bist(-1, 150, cyc);
      chk("rst_aborted", 32'(cyc), 32'hFFFF_FFFF);
      repeat (3) @(posedge clk);
      #1 chk("idle_after_rst", 32'({busy, done, write, read}), 32'd0);
      set_fault(8'h00, 8'hFF, 1'b0, 5'd0, 8'h00);
      run_bist(-1, -1, cyc);
      check_run("post_rst", cyc, 0, 0, 1'b1);

      for (int r = 0; r < 6; r++) begin
         kind = int'($urandom_range(0, 2));
         set_fault(8'h00, 8'hFF, 1'b0, 5'd0, 8'h00);
         if (kind == 0)      or_m  = 8'(8'h01 << $urandom_range(0, 7));
         else if (kind == 1) and_m = ~8'(8'h01 << $urandom_range(0, 7));
         else begin
            bad_en = 1'b1;
            bad_a  = 5'($urandom_range(0, 31));
            bad_v  = 8'($urandom_range(0, 255));
         end
         model(e, f);
         repeat ($urandom_range(0, 4)) @(posedge clk);
         run_bist(-1, -1, cyc);
         check_run($sformatf("rand%0d", r), cyc, e, f, (e == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
